bits_to_bytes_packer: RTL
=========================

// Module: bits_to_bytes_packer
// PURPOSE
// - Streaming inverse of the byte-to-bit unpacker: packs LSB-first IN_W-bit chunks into bytes.
// - Sits after coefficient compress/encode stages; feeds byte sinks (hash, ciphertext/key buffers).
// - Valid/ready on both sides; a message ends on an input beat with in_last=1.
// - The final partial byte is zero-padded and flagged with out_last.
// PARAMETERS
// - IN_W        1    bits per input beat, legal 1..8 (8 = byte passthrough)
// - BYTE_COUNT  128  max bytes per message; sizes byte_cnt, overflow check
// PORTS
// - clk       in   1                       clock; all logic on rising edge
// - rst       in   1                       synchronous reset, active-high
// - in_valid  in   1                       input chunk valid
// - in_ready  out  1                       packer accepts chunk
// - in_bits   in   IN_W                    chunk; bit 0 is earliest in stream
// - in_last   in   1                       chunk is last of message (qualified by in_valid)
// - out_valid out  1                       out_byte valid
// - out_ready in   1                       sink accepts byte
// - out_byte  out  8                       packed byte; bit 0 = earliest bit
// - out_last  out  1                       final byte of message
// - byte_cnt  out  $clog2(BYTE_COUNT)+1   bytes handed off in current message
// - err       out  1                       sticky: message exceeded BYTE_COUNT bytes
// BEHAVIOUR
// - Clock clk; reset rst is synchronous, active-high.
// - Reset: state=ACCUM, acc=0, fill=0, byte_cnt=0, err=0.
//   Outputs: in_ready=1, out_valid=0, out_last=0, out_byte=0.
// - Reset mid-message drops all buffered bits; no byte emitted.
// - Storage: acc[14:0] and fill (0..15), the number of valid bits.
//   Bits at or above fill are always 0, so padding is implicit.
// - Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
// - out_byte = acc[7:0]; held stable while out_valid & !out_ready.
// - State ACCUM:
//   - in_ready = (fill<8) | out_ready. This is a deliberate combinational out_ready->in_ready path.
//   - out_valid = (fill>=8); out_last = 0.
// - State FLUSH:
//   - in_ready = 0; out_valid = (fill>0); out_last = (fill<=8).
// - Per-cycle update, with pop = out_fire:
//   - If pop: acc >>= 8, fill -= 8, saturating at 0 for the padded last byte.
//   - Then if in_fire: acc |= in_bits << fill, fill += IN_W.
//   - Simultaneous pop and push is legal; fill never exceeds 15.
// - Transitions:
//   - ACCUM -> FLUSH on in_fire & in_last. Fill is then >=1, so FLUSH always emits >=1 byte.
//   - FLUSH -> ACCUM on out_fire & out_last; acc=0, fill=0.
// - Latency: the byte completed by an input beat has out_valid the next cycle.
// - Throughput: one byte per cycle (IN_W=8) or one byte per 8/IN_W beats, with no bubbles under out_ready=1.
// - byte_cnt:
//   - Increments on each out_fire.
//   - Clears to 0 on the cycle after the out_last handshake; holds otherwise.
// - err: set when out_fire occurs with byte_cnt==BYTE_COUNT. Packing continues; only rst clears err.
// - in_valid/in_bits/in_last must stay stable until in_fire. Behaviour is undefined if they change earlier.
// TESTING
// - IN_W=1: 1024 bits of the 128-byte KAT vector (first byte 0xB9), in_last on bit 1023, out_ready=1
//   -> 128 bytes equal to the vector, out_last only on byte 127, byte_cnt=128.
// - IN_W=3: chunks 3'b101, 3'b011, 3'b111 (last)
//   -> out_byte 0xDD (out_last=0), then 0x01 (out_last=1).
// - IN_W=8: 0xB9, 0x31 (last), back-to-back, out_ready=1
//   -> 0xB9 then 0x31/out_last, each 1 cycle after its input beat; in_ready never drops.
// - IN_W=1, random out_ready low 50% of cycles
//   -> byte stream identical to the first test; out_byte stable while stalled; no bit lost or duplicated.
// - Reset mid-message after 13 bits, then a fresh 16-bit message 0x5A, 0xC3
//   -> outputs exactly 0x5A, 0xC3 (last); byte_cnt=2.
// - BYTE_COUNT=4, 5-byte message
//   -> err rises on the 5th out_fire and stays 1 until rst; all 5 bytes emitted.

Source files
------------

// File: rtl/bits_to_bytes_packer.sv
`default_nettype none
// ============================================================================
// Module      : bits_to_bytes_packer
// Description : Streaming packer that gathers LSB-first IN_W-bit chunks into
//               bytes with valid/ready on both sides. A message ends on an
//               input beat flagged in_last; the trailing partial byte is
//               zero-padded and marked with out_last. Counts bytes per
//               message and raises a sticky error once the message grows
//               past BYTE_COUNT bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module bits_to_bytes_packer #(
  parameter int IN_W       = 1,
  parameter int BYTE_COUNT = 128,
  localparam int CNT_W     = $clog2(BYTE_COUNT) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_bits,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             err
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LIMIT = CNT_W'(BYTE_COUNT);
  localparam logic [CNT_W-1:0] C_CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [3:0]       C_IN_W      = 4'(IN_W);

  state_t           state_q, state_d;
  logic [14:0]      acc_q, acc_d;     // bit 0 is the earliest buffered bit
  logic [3:0]       fill_q, fill_d;   // number of valid bits in acc_q
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clr_q, clr_d;     // last byte just handed off
  logic             err_q, err_d;

  logic             w_in_fire;
  logic             w_out_fire;
  logic [14:0]      w_acc_pop;
  logic [3:0]       w_fill_pop;
  logic [14:0]      w_in_ext;

  // Handshake outputs derived from the current state and fill level.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        // out_ready feeds in_ready directly so a full byte and a new chunk
        // can move in the same cycle.
        in_ready  = (fill_q < 4'd8) | out_ready;
        out_valid = (fill_q >= 4'd8);
      end
      ST_FLUSH: begin
        out_valid = (fill_q != 4'd0);
        out_last  = (fill_q != 4'd0) && (fill_q <= 4'd8);
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
      end
    endcase
  end

  assign out_byte   = acc_q[7:0];
  assign byte_cnt   = cnt_q;
  assign err        = err_q;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_in_ext   = {{(15-IN_W){1'b0}}, in_bits};

  // Next-state: pop the head byte first, then append the new chunk above
  // whatever remains, then resolve state and byte-counter updates.
  always_comb begin
    w_acc_pop  = acc_q;
    w_fill_pop = fill_q;
    if (w_out_fire) begin
      w_acc_pop  = acc_q >> 8;
      // Saturate at zero: the padded final byte may hold fewer than 8 bits.
      w_fill_pop = (fill_q >= 4'd8) ? (fill_q - 4'd8) : 4'd0;
    end

    acc_d  = w_acc_pop;
    fill_d = w_fill_pop;
    if (w_in_fire) begin
      acc_d  = w_acc_pop | (w_in_ext << w_fill_pop);
      fill_d = w_fill_pop + C_IN_W;
    end

    state_d = state_q;
    case (state_q)
      ST_ACCUM: begin
        if (w_in_fire && in_last) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (w_out_fire && out_last) begin
          state_d = ST_ACCUM;
          acc_d   = 15'd0;
          fill_d  = 4'd0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase

    // The count shows the full message length for one cycle after the
    // last byte, then returns to zero for the next message.
    cnt_d = clr_q ? {CNT_W{1'b0}} : cnt_q;
    if (w_out_fire && (cnt_d != C_CNT_MAX)) begin
      cnt_d = cnt_d + 1'b1;
    end
    clr_d = w_out_fire & out_last;
    err_d = err_q | (w_out_fire & (cnt_q == C_CNT_LIMIT));
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= 15'd0;
      fill_q  <= 4'd0;
      cnt_q   <= {CNT_W{1'b0}};
      clr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire
